// File: rtl/uart_status_tx.sv
// uart_status_tx: formats and sends an 8-byte ASCII status frame "M:dddd\r\n" over a start/done UART handshake
module uart_status_tx #(
  parameter int CNT_W = 14,
  parameter int REPORT_PERIOD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] i_count,
  input  logic             i_run_on,
  input  logic             i_clr_on,
  input  logic             i_report,
  input  logic             i_tx_done,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_start,
  output logic             o_busy
);
  localparam int PW = REPORT_PERIOD > 1 ? $clog2(REPORT_PERIOD) : 1;
  localparam int CW = $clog2(CNT_W + 1);
  typedef enum logic [2:0] {IDLE, CONV, SEND, WAIT, NEXT} state_t;
  state_t state;
  logic [7:0] mode_c, prev_mode, snap_mode, cur_byte;
  logic [CNT_W-1:0] bin, clamped;
  logic [15:0] bcd, bcd_adj;
  logic [CW-1:0] cyc;
  logic [2:0] idx;
  logic [PW-1:0] per_cnt;
  logic pending, per_trig, trig;
  function automatic logic [15:0] dabble(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int k = 0; k < 4; k++) if (r[4*k +: 4] > 4'd4) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
    return r;
  endfunction
  // mode character, trigger sources, clamped count and the byte selected by the frame index
  always_comb begin
    mode_c = i_clr_on ? 8'h43 : i_run_on ? 8'h52 : 8'h53;
    per_trig = (REPORT_PERIOD > 0) && (per_cnt == PW'(REPORT_PERIOD - 1));
    trig = (mode_c != prev_mode) || i_report || per_trig;
    clamped = (i_count > CNT_W'(9999)) ? CNT_W'(9999) : i_count;
    bcd_adj = dabble(bcd);
    cur_byte = idx == 3'd0 ? snap_mode :
               idx == 3'd1 ? 8'h3A :
               idx == 3'd2 ? {4'h3, bcd[15:12]} :
               idx == 3'd3 ? {4'h3, bcd[11:8]} :
               idx == 3'd4 ? {4'h3, bcd[7:4]} :
               idx == 3'd5 ? {4'h3, bcd[3:0]} :
               idx == 3'd6 ? 8'h0D : 8'h0A;
  end
  // frame sequencer: snapshot, double-dabble conversion, then byte-by-byte handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      o_tx_data <= '0;
      o_tx_start <= 1'b0;
      o_busy <= 1'b0;
      pending <= 1'b0;
      per_cnt <= '0;
      prev_mode <= 8'h53;
      snap_mode <= 8'h53;
      bin <= '0;
      bcd <= '0;
      cyc <= '0;
      idx <= '0;
    end else begin
      prev_mode <= mode_c;
      if (REPORT_PERIOD > 0) per_cnt <= per_trig ? '0 : per_cnt + 1'b1;
      if (trig && o_busy) pending <= 1'b1;
      o_tx_start <= 1'b0;
      case (state)
        IDLE: if (trig || pending) begin
          snap_mode <= mode_c;
          bin <= clamped;
          bcd <= '0;
          cyc <= '0;
          pending <= 1'b0;
          o_busy <= 1'b1;
          state <= CONV;
        end
        CONV: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          cyc <= cyc + 1'b1;
          if (cyc == CW'(CNT_W - 1)) begin
            idx <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          o_tx_start <= 1'b1;
          o_tx_data <= cur_byte;
          state <= WAIT;
        end
        WAIT: if (i_tx_done) state <= NEXT;
        NEXT: if (idx == 3'd7) begin
          o_busy <= 1'b0;
          state <= IDLE;
        end else begin
          idx <= idx + 3'd1;
          state <= SEND;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
